keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Upstream stage of the calculator's main control FSM.
- Scans a 4x4 active-low matrix keypad, synchronises and debounces the columns, and encodes the pressed key into a 4-bit key code.
- Emits exactly one single-cycle kbEN strobe per physical press. pressedkey is valid at the strobe and held stable until the next strobe.
- Output pair pressedkey/kbEN connects directly to the main FSM's pressedkey/kbEN inputs.

Parameters:
- SCAN_DIV, 1000, clock cycles per scan tick (row dwell time); minimum 2.
- DEBOUNCE_TICKS, 4, consecutive agreeing scan ticks required to accept a press or a release; minimum 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset (0 = reset).
- cols_n  input  4  keypad column lines, active-low, asynchronous to clk.
- rows_n  output  4  keypad row drive, one-hot-low.
- pressedkey  output  4  key code of the last accepted press.
- kbEN  output  1  one-cycle strobe: new key accepted.

Behaviour:
- Reset is sampled on the rising edge of clk, is synchronous and active-low, and takes priority over all other logic. Reset values:
  - rows_n = 4'b1110 (row 0 driven).
  - pressedkey = 0, kbEN = 0.
  - state = SCAN; row index, prescaler and debounce counters = 0.
  - synchroniser flops = 4'b1111.
- Reset asserted mid-operation, including during WAIT_RELEASE or EMIT, aborts immediately. kbEN is 0 from the first reset edge. A key still held after reset is re-detected and emitted again.
- cols_n passes through a 2-flop synchroniser. All decisions use the synchronised value (cs_n).
- Prescaler counts 0..SCAN_DIV-1 and wraps. tick = 1 for one cycle when the count equals SCAN_DIV-1. Each row therefore dwells SCAN_DIV cycles before it is sampled.
- Key map, row r / col c (code):
  - r0: 1, 2, 3, 12(plus)
  - r1: 4, 5, 6, 13(minus)
  - r2: 7, 8, 9, 14(mult)
  - r3: 11(AC), 0, 10(equal), 15(div)
- State machine, with transitions evaluated only on tick except EMIT:
  - SCAN, no key low: if cs_n == 4'b1111, advance the row index (3 wraps to 0) and drive the new row.
  - SCAN, key low: otherwise latch the row and the lowest-indexed low column; set count = 1; go to DEBOUNCE.
  - DEBOUNCE, key still low: row held. If the latched column is still low, count++. When count reaches DEBOUNCE_TICKS, go to EMIT.
  - DEBOUNCE, key released: if the latched column is high, go to SCAN and advance the row.
  - DEBOUNCE, DEBOUNCE_TICKS = 1: the move to EMIT happens on the next cycle.
  - EMIT: lasts exactly 1 cycle. kbEN = 1 and pressedkey = map(row, col), both registered. Next state is WAIT_RELEASE with count = 0.
  - WAIT_RELEASE: row held. If cs_n == 4'b1111, count++; any low column resets count to 0. When count reaches DEBOUNCE_TICKS, go to SCAN and advance the row.
- Simultaneous keys:
  - Same row: the lowest column index wins.
  - Different rows: the first row reached by the scan wins.
  - Other keys pressed during WAIT_RELEASE are ignored until every key has been released.
- kbEN is never high for more than one consecutive cycle. Every kbEN pulse is separated by at least DEBOUNCE_TICKS release ticks.
- pressedkey changes only in the EMIT cycle.
- Latency from a stable press to kbEN is at most (4 + DEBOUNCE_TICKS + 1) * SCAN_DIV + 3 cycles.
- Counter widths: $clog2(SCAN_DIV) for the prescaler, $clog2(DEBOUNCE_TICKS+1) for the debounce counter. The debounce counter saturates and never wraps.

Decomposition:
- Shared package calc_pkg holds:
  - key code constants KEY_EQUAL = 10, KEY_AC = 11, KEY_PLUS = 12, KEY_MINUS = 13, KEY_MULT = 14, KEY_DIV = 15. These are the same constants the main FSM uses.
  - the state enum for this block.
  - the 16-entry key map function.
- One sub-module: sync_2ff, a 4-bit, two-stage synchroniser with parameterised reset value 1. Reusable for the other asynchronous inputs.
- Prescaler and FSM stay in keypad_scanner.

Test Plan (SCAN_DIV = 4, DEBOUNCE_TICKS = 2; keypad model pulls the addressed column low only while its row is driven):
- Reset: hold reset = 0 for 3 cycles with cols_n = 4'b1111 -> rows_n = 4'b1110, kbEN = 0, pressedkey = 0. Release reset -> rows_n rotates 1110 -> 1101 -> 1011 -> 0111 every 4 cycles.
- Single press, key r0/c0 held 200 cycles -> exactly one kbEN pulse of 1 cycle, pressedkey = 1, within the latency bound. No second pulse while held.
- Bounce: r1/c1 low for 1 tick only, then released -> no kbEN; scan resumes at row 2.
- Sequence 1, plus, 1, equal (r0c0, r0c3, r0c0, r3c2), each key released for 20 cycles -> four kbEN pulses with pressedkey 1, 12, 1, 10.
- Same-row double press r2c1 + r2c3 -> a single pulse with pressedkey = 8. Pressing r0c0 during WAIT_RELEASE -> no pulse until all keys are released.
- Reset mid-WAIT_RELEASE with r3c0 held -> kbEN stays 0 during reset. After release of reset, one new pulse with pressedkey = 11.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, keypad scanner states and the
// keypad row/column helpers used by the scanner.
package calc_pkg;

    localparam logic [3:0] KEY_EQUAL = 4'd10;
    localparam logic [3:0] KEY_AC    = 4'd11;
    localparam logic [3:0] KEY_PLUS  = 4'd12;
    localparam logic [3:0] KEY_MINUS = 4'd13;
    localparam logic [3:0] KEY_MULT  = 4'd14;
    localparam logic [3:0] KEY_DIV   = 4'd15;

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        EMIT         = 2'd2,
        WAIT_RELEASE = 2'd3
    } kp_state_e;

    // Physical keypad layout: row-major, column 3 holds the operators.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code_s;
        case ({row, col})
            4'd0:    code_s = 4'd1;
            4'd1:    code_s = 4'd2;
            4'd2:    code_s = 4'd3;
            4'd3:    code_s = KEY_PLUS;
            4'd4:    code_s = 4'd4;
            4'd5:    code_s = 4'd5;
            4'd6:    code_s = 4'd6;
            4'd7:    code_s = KEY_MINUS;
            4'd8:    code_s = 4'd7;
            4'd9:    code_s = 4'd8;
            4'd10:   code_s = 4'd9;
            4'd11:   code_s = KEY_MULT;
            4'd12:   code_s = KEY_AC;
            4'd13:   code_s = 4'd0;
            4'd14:   code_s = KEY_EQUAL;
            4'd15:   code_s = KEY_DIV;
            default: code_s = 4'd0;
        endcase
        return code_s;
    endfunction

    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        logic [3:0] drv_s;
        case (idx)
            2'd0:    drv_s = 4'b1110;
            2'd1:    drv_s = 4'b1101;
            2'd2:    drv_s = 4'b1011;
            2'd3:    drv_s = 4'b0111;
            default: drv_s = 4'b1110;
        endcase
        return drv_s;
    endfunction

    // Lowest-indexed low column wins when several keys share a row.
    function automatic logic [1:0] low_col(input logic [3:0] cs_n);
        logic [1:0] col_s;
        if (!cs_n[0]) begin
            col_s = 2'd0;
        end else if (!cs_n[1]) begin
            col_s = 2'd1;
        end else if (!cs_n[2]) begin
            col_s = 2'd2;
        end else begin
            col_s = 2'd3;
        end
        return col_s;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchroniser for asynchronous level inputs; resets to an
// inactive (all-ones by default) value so active-low lines read as idle.
module sync_2ff #(
    parameter int             W         = 4,
    parameter logic [W-1:0]   RESET_VAL = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_r;

    // Both stages reset together so no stale level leaks out after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_r <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: row scan, column debounce and a
// single kbEN strobe with the encoded key per physical press.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols_n,
    output logic [3:0] rows_n,
    output logic [3:0] pressedkey,
    output logic       kbEN
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [PW-1:0] PS_MAX  = PW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_TGT  = CW'(DEBOUNCE_TICKS);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [3:0]    cs_n_s;
    logic [PW-1:0] presc_r;
    logic          tick_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] cnt_inc_s;
    logic [1:0]    row_r;
    logic [1:0]    col_r;
    logic          all_high_s;
    logic          col_low_s;
    kp_state_e     state_r;

    sync_2ff #(.W(4), .RESET_VAL(4'b1111)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (cols_n),
        .q     (cs_n_s)
    );

    assign tick_s     = (presc_r == PS_MAX);
    assign all_high_s = (cs_n_s == 4'b1111);
    assign col_low_s  = ~cs_n_s[col_r];
    assign cnt_inc_s  = (count_r == CNT_MAX) ? count_r : count_r + CW'(1);

    // Row dwell prescaler: one tick every SCAN_DIV cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_r <= {PW{1'b0}};
        end else if (tick_s) begin
            presc_r <= {PW{1'b0}};
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Scan / debounce / emit / release FSM with registered row drive and outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= SCAN;
            row_r      <= 2'd0;
            col_r      <= 2'd0;
            count_r    <= {CW{1'b0}};
            rows_n     <= 4'b1110;
            pressedkey <= 4'd0;
            kbEN       <= 1'b0;
        end else begin
            kbEN <= 1'b0;
            case (state_r)
                SCAN: begin
                    if (tick_s) begin
                        if (all_high_s) begin
                            row_r  <= row_r + 2'd1;
                            rows_n <= row_drive(row_r + 2'd1);
                        end else begin
                            col_r   <= low_col(cs_n_s);
                            count_r <= CW'(1);
                            state_r <= DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    // Target check is not tick-gated so DEBOUNCE_TICKS=1 emits next cycle.
                    if (count_r >= DB_TGT) begin
                        state_r    <= EMIT;
                        kbEN       <= 1'b1;
                        pressedkey <= key_map(row_r, col_r);
                    end else if (tick_s) begin
                        if (col_low_s) begin
                            count_r <= cnt_inc_s;
                        end else begin
                            state_r <= SCAN;
                            row_r   <= row_r + 2'd1;
                            rows_n  <= row_drive(row_r + 2'd1);
                        end
                    end
                end
                EMIT: begin
                    state_r <= WAIT_RELEASE;
                    count_r <= {CW{1'b0}};
                end
                WAIT_RELEASE: begin
                    if (tick_s) begin
                        if (!all_high_s) begin
                            count_r <= {CW{1'b0}};
                        end else if (cnt_inc_s >= DB_TGT) begin
                            state_r <= SCAN;
                            count_r <= {CW{1'b0}};
                            row_r   <= row_r + 2'd1;
                            rows_n  <= row_drive(row_r + 2'd1);
                        end else begin
                            count_r <= cnt_inc_s;
                        end
                    end
                end
                default: begin
                    state_r <= SCAN;
                end
            endcase
        end
    end

endmodule
